// File: rtl/router_pkg.sv
// Shared router definitions: default packet width, packet type, header field slices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package router_pkg;

  // Default packet width used by every router stage.
  localparam int PCKG_SZ_DEFAULT = 40;

  typedef logic [PCKG_SZ_DEFAULT-1:0] pkt_t;

  // Header field positions inside a packet, consumed by routing stages downstream.
  localparam int TRGT_ID_MSB = 39;
  localparam int TRGT_ID_LSB = 32;
  localparam int SRC_ID_MSB  = 31;
  localparam int SRC_ID_LSB  = 24;

  // True for powers of two that are at least 2; used to validate buffer depths.
  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/router_port_fifo_if.sv
// Handshake bundle between a port driver, its ingress FIFO and the arbiter.
// Latency: n/a (wires only).
// Backpressure: full/ovf report drops to the writer; udf flags a pop with nothing pending.
// Signals: push/data_in (writer -> FIFO), pop (arbiter -> FIFO),
//          data_out/pndng/full/count/ovf/udf (FIFO -> writer/arbiter).
interface router_port_fifo_if
  import router_pkg::*;
#(
  parameter int PCKG_SZ = PCKG_SZ_DEFAULT,
  parameter int DEPTH   = 16
) ();

  logic                     push;
  logic [PCKG_SZ-1:0]       data_in;
  logic                     pop;
  logic [PCKG_SZ-1:0]       data_out;
  logic                     pndng;
  logic                     full;
  logic [$clog2(DEPTH):0]   count;
  logic                     ovf;
  logic                     udf;

  // Writer/arbiter side.
  modport master (
    output push, data_in, pop,
    input  data_out, pndng, full, count, ovf, udf
  );

  // FIFO side.
  modport slave (
    input  push, data_in, pop,
    output data_out, pndng, full, count, ovf, udf
  );

  // Passive observer (property checker).
  modport mon (
    input push, data_in, pop, data_out, pndng, full, count, ovf, udf
  );

endinterface

// File: rtl/router_port_fifo_sva.sv
// Property checker for router_port_fifo, attached alongside the FIFO on the same interface.
// Latency: n/a (observes only).
// Backpressure: n/a; never drives the interface.
// Ports: clk, reset; port (mon modport) carrying every FIFO handshake signal.
module router_port_fifo_sva #(
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  router_port_fifo_if.mon  port
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  a_full_implies_pndng: assert property (
    @(posedge clk) disable iff (reset) !(port.full && !port.pndng)
  ) else $error("router_port_fifo_sva: full asserted while nothing pending");

  a_count_bound: assert property (
    @(posedge clk) disable iff (reset) (port.count <= DEPTH_C)
  ) else $error("router_port_fifo_sva: count exceeds DEPTH");

  // The arbiter relies on an unpopped head staying put, even while new packets are written behind it.
  a_head_stable: assert property (
    @(posedge clk) disable iff (reset) (port.pndng && !port.pop) |=> $stable(port.data_out)
  ) else $error("router_port_fifo_sva: head changed without a pop");

endmodule

// File: rtl/router_port_fifo.sv
// Per-port first-word-fall-through ingress packet buffer feeding the round-robin arbiter.
// Latency: a push into an empty FIFO is visible on data_out/pndng after the next edge (no bypass).
// Backpressure: push while full without pop is dropped (ovf pulse); pop while empty is ignored (udf pulse).
// Ports: clk, reset (async, active-high); port (slave modport): push, data_in, pop in;
//        data_out (head or zero), pndng, full, count, ovf, udf out.
module router_port_fifo
  import router_pkg::*;
#(
  parameter int PCKG_SZ = PCKG_SZ_DEFAULT,
  parameter int DEPTH   = 16
) (
  input  logic               clk,
  input  logic               reset,
  router_port_fifo_if.slave  port
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if (!is_pow2(DEPTH)) begin : g_depth_chk
    $error("router_port_fifo: DEPTH must be a power of two and at least 2");
  end

  // Storage is deliberately left out of reset; validity is tracked by count_q.
  logic [PCKG_SZ-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          ovf_q,    ovf_d;
  logic          udf_q,    udf_d;

  logic pndng;
  logic full;
  logic wr_en;
  logic rd_en;

  assign pndng = (count_q != '0);
  assign full  = (count_q == DEPTH_C);

  // A simultaneous pop frees the slot this push needs, so a full FIFO still accepts it.
  assign wr_en = port.push & (~full | port.pop);
  assign rd_en = port.pop & pndng;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;

    // Pointers are exactly log2(DEPTH) wide, so the increment wraps on its own.
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    ovf_d = port.push & full & ~port.pop;
    udf_d = port.pop & ~pndng;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= port.data_in;
    end
  end

  // Head is driven from the registered read pointer so the arbiter can mux it in the pop cycle.
  assign port.data_out = pndng ? mem_q[rd_ptr_q] : '0;
  assign port.pndng    = pndng;
  assign port.full     = full;
  assign port.count    = count_q;
  assign port.ovf      = ovf_q;
  assign port.udf      = udf_q;

endmodule

// File: doc/router_port_fifo.md
Name: router_port_fifo

Overview:
- Per-port ingress packet buffer. One instance per router port, NUM instances in total.
- Sits directly upstream of the round-robin arbiter and feeds it. Drives pndng and data_out into the arbiter's pndng_i[k] and data_out_i[k] inputs; the arbiter's per-port pop returns here.
- First-word-fall-through (FWFT): the head packet is always presented on data_out while pndng=1, so the arbiter can mux and push it in the same cycle it asserts pop.

Parameters:
- PCKG_SZ, 40, packet width in bits.
- DEPTH, 16, entries. Must be a power of two, >= 2; elaborate-time assertion otherwise.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- push  input  1  write request from the upstream port driver/agent.
- data_in  input  PCKG_SZ  packet to write; sampled when push=1.
- pop  input  1  read request from the arbiter; removes the head entry.
- data_out  output  PCKG_SZ  head entry when pndng=1, else all zeros.
- pndng  output  1  FIFO not empty.
- full  output  1  count == DEPTH.
- count  output  $clog2(DEPTH)+1  number of stored entries.
- ovf  output  1  one-cycle pulse: push dropped because the FIFO was full.
- udf  output  1  one-cycle pulse: pop ignored because the FIFO was empty.

Behaviour:
- Reset (async assert, sync-released by the system): wr_ptr=0, rd_ptr=0, count=0, pndng=0, full=0, ovf=0, udf=0, data_out=0. Storage contents are not reset.
- Pointers are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0 naturally.
- wr_en = push & (~full | pop). rd_en = pop & pndng.
- Write: mem[wr_ptr] <= data_in, wr_ptr++ on wr_en. Read: rd_ptr++ on rd_en.
- count next value:
  - +1 if wr_en & ~rd_en
  - -1 if rd_en & ~wr_en
  - unchanged otherwise
- pndng = (count != 0) and full = (count == DEPTH), both registered-state derived. data_out = pndng ? mem[rd_ptr] : 0, combinational from the registered pointer.
- Latency: a packet pushed into an empty FIFO at edge N appears on data_out with pndng=1 after edge N. There is no same-cycle bypass.
- Full + push + pop in the same cycle: both accepted. Count stays DEPTH, full stays 1, ovf=0.
- Full + push, no pop: write dropped, state unchanged, ovf=1 for the following cycle.
- Empty + pop: ignored, udf=1 for the following cycle.
- Empty + push + pop in the same cycle: push accepted, pop ignored, udf=1, count -> 1.
- ovf and udf are registered and clear the cycle after unless re-triggered.
- Reset mid-operation: all state and outputs return to reset values immediately (async). Any push or pop in flight is lost.
- Interface contract with the arbiter: the arbiter asserts pop only with pndng=1, and data_out is stable from the pop cycle back to the prior edge. udf=1 therefore flags an arbiter protocol violation.

Decomposition:
- Shared router_pkg holds:
  - PCKG_SZ default constant.
  - pkt_t typedef (logic [PCKG_SZ-1:0]).
  - Field-slice localparams for target and source IDs, used by later stages.
- No sub-module. Storage, pointers and counters stay in a single module.
- A companion checker, router_port_fifo_sva, is bound separately. It asserts:
  - ~(full & pndng==0)
  - count <= DEPTH
  - data_out stability while pndng & ~pop

Test Plan:
- Reset with DEPTH=16, then push 0x01..0x03 on consecutive cycles, no pop -> count=3, pndng=1, data_out=0x01 from the cycle after the first push.
- Fill 16 entries 0x10..0x1F, then push 0xAA -> full=1, ovf pulses 1 cycle, count=16. Pop 16 times -> outputs 0x10..0x1F in order, 0xAA never appears.
- With full=1, push 0x55 and pop together -> count stays 16, ovf=0, data_out advances to the next entry, 0x55 read last.
- Empty FIFO, push 0x77 and pop in the same cycle -> udf=1, count=1, data_out=0x77 next cycle.
- Push and pop every cycle for 40 cycles with distinct values -> pointers wrap at 16 with no data loss and order preserved.
- Assert reset with count=5 mid-burst -> pndng=0, data_out=0, count=0 with no clock edge required. After release, the next push reads back correctly.
